// File: rtl/channel_mux_arb.sv
// channel_mux_arb: CHANNELS-way select/arbiter feeding a one-entry output reg.
// Define CHANNEL_MUX_ARB_RR_EN for round-robin arbitration (default: fixed).
module channel_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      sel_mode,
  input  logic [CW-1:0]             sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic          load_ok;
  logic          gnt_any;
  logic [CW-1:0] gnt;
  logic          xfer;
  int            idx;

`ifdef CHANNEL_MUX_ARB_RR_EN
  logic [CW-1:0] rr_ptr;
`endif

  assign load_ok = ~out_valid | out_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (sel_mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt     = CW'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
`ifdef CHANNEL_MUX_ARB_RR_EN
        idx = (int'(rr_ptr) + k) % CHANNELS;
`else
        idx = k;
`endif
        if (!gnt_any && in_valid[idx]) begin
          gnt_any = 1'b1;
          gnt     = CW'(idx);
        end
      end
    end
  end

  // reset gates ready so nothing is accepted while held in reset
  assign xfer = gnt_any & load_ok & resetn;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer && (int'(gnt) == i);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
      out_chan  <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CHANNEL_MUX_ARB_RR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (xfer && !sel_mode) begin
      rr_ptr <= CW'((int'(gnt) + 1) % CHANNELS);
    end
  end
`endif

endmodule

// File: tb/tb_channel_mux_arb.sv
// tb_channel_mux_arb: directed + random checks of channel_mux_arb against
// a transaction-level model; honours CHANNEL_MUX_ARB_RR_EN.
module tb_channel_mux_arb;

  localparam int CH = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        sel_mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        sel_mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int n_cmp = 0;
  int n_fail = 0;

  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;

  always #5 clock = ~clock;

  channel_mux_arb #(.WIDTH(8), .CHANNELS(4)) dut (
    .clock(clock), .resetn(resetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_mode(sel_mode), .sel(sel),
    .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  channel_mux_arb #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clock(clock), .resetn(resetn),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel_mode(sel_mode3), .sel(sel3),
    .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  function automatic int exp_grant();
    if (sel_mode)
      return (int'(sel) < CH && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < CH; k++) begin
      int c;
`ifdef CHANNEL_MUX_ARB_RR_EN
      c = (m_ptr + k) % CH;
`else
      c = k;
`endif
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    if (g >= 0 && (!m_valid || out_ready)) return 4'(1 << g);
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
  endtask

  task automatic step();
    int g;
    g = exp_grant();
    if (g >= 0 && (!m_valid || out_ready)) begin
      m_valid = 1;
      m_data  = in_data[g*8 +: 8];
      m_chan  = g;
      if (!sel_mode) m_ptr = (g + 1) % CH;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    in_valid = '0;
    in_valid3 = '0;
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 4'hf; in_data = 32'h44332211;
    sel_mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_valid3 = 3'b111; in_data3 = '0;
    sel_mode3 = 1'b1; sel3 = 2'd0; out_ready3 = 1'b1;
    model_reset();
    #12;
    n_cmp++;
    if (in_ready !== 4'b0) begin
      n_fail++; $display("FAIL reset_in_ready got=%b want=0000", in_ready);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'h00 || out_chan !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_out_word got=%h/%0d want=00/0", out_data, out_chan);
    end
    resetn = 1'b1;
  endtask

  task automatic test_direct();
    reset_dut();
    sel_mode = 1'b1; sel = 2'd2; in_valid = 4'b1111;
    in_data = 32'h11A5_2233; out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL direct_ready got=%b want=0100", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      n_fail++;
      $display("FAIL direct_out got=%b/%h/%0d want=1/a5/2",
               out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_arbitrate();
    int want[5];
`ifdef CHANNEL_MUX_ARB_RR_EN
    want = '{0, 1, 2, 3, 0};
`else
    want = '{0, 0, 0, 0, 0};
`endif
    reset_dut();
    sel_mode = 1'b0; in_valid = 4'b1111;
    in_data = 32'h4433_2211; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || int'(out_chan) != want[i]) begin
        n_fail++;
        $display("FAIL arb_seq[%0d] got=%b/%0d want=1/%0d",
                 i, out_valid, out_chan, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    sel_mode = 1'b0; in_valid = 4'b0001;
    in_data = 32'h0000_5A3C; out_ready = 1'b0;
    step();
    in_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 4'b0 || out_data !== 8'h3C || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got=%b/%h/%b want=0000/3c/1",
                 i, in_ready, out_data, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release_ready got=%b want=0010", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_release_out got=%b/%h/%0d want=1/5a/1",
               out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    sel_mode = 1'b0; in_valid = 4'b0100;
    in_data = 32'h0077_0000; out_ready = 1'b0;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_chan !== 2'd2) begin
      n_fail++;
      $display("FAIL arst_pre got=%b/%0d want=1/2", out_valid, out_chan);
    end
    out_ready = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_chan !== 2'd0 || in_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL arst_now got=%b/%h/%0d/%b want=0/00/0/0000",
               out_valid, out_data, out_chan, in_ready);
    end
    #1;
    resetn = 1'b1;
    in_valid = 4'b1001; in_data = 32'hD0_0000_E1;
    #1;
    n_cmp++;
    if (in_ready !== exp_ready()) begin
      n_fail++;
      $display("FAIL arst_first_ready got=%b want=%b", in_ready, exp_ready());
    end
    step();
    n_cmp++;
    if (int'(out_chan) != m_chan || out_data !== m_data) begin
      n_fail++;
      $display("FAIL arst_first_out got=%0d/%h want=%0d/%h",
               out_chan, out_data, m_chan, m_data);
    end
  endtask

  task automatic test_out_of_range();
    sel_mode3 = 1'b1; sel3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = 24'hCC_BB_AA; out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready3 !== 3'b000) begin
        n_fail++; $display("FAIL oor_ready[%0d] got=%b want=000", i, in_ready3);
      end
      @(posedge clock); #1;
      n_cmp++;
      if (out_valid3 !== 1'b0) begin
        n_fail++; $display("FAIL oor_valid[%0d] got=%b want=0", i, out_valid3);
      end
    end
    sel3 = 2'd1;
    #1;
    n_cmp++;
    if (in_ready3 !== 3'b010) begin
      n_fail++; $display("FAIL oor_inrange_ready got=%b want=010", in_ready3);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'hBB || out_chan3 !== 2'd1) begin
      n_fail++;
      $display("FAIL oor_inrange_out got=%b/%h/%0d want=1/bb/1",
               out_valid3, out_data3, out_chan3);
    end
    in_valid3 = '0;
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      sel_mode  = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_fail++;
        $display("FAIL rnd_ready[%0d] got=%b want=%b", i, in_ready, exp_ready());
      end
      step();
      n_cmp++;
      if (out_valid !== m_valid || out_data !== m_data ||
          int'(out_chan) != m_chan) begin
        n_fail++;
        $display("FAIL rnd_out[%0d] got=%b/%h/%0d want=%b/%h/%0d",
                 i, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_direct();
    test_arbitrate();
    test_backpressure();
    test_async_reset();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_mux_arb.md
CHANNEL_MUX_ARB -- requirements
Module: channel_mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per channel data word (>=1).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (>=1); CW = max(1, clog2(CHANNELS)).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port in_valid  input  CHANNELS  channel i word present.
REQ-007 SHALL have port in_ready  output  CHANNELS  channel i word accepted this cycle when in_valid[i] also high.
REQ-008 SHALL have port sel_mode  input  1  1 = direct select via sel; 0 = arbitrated.
REQ-009 SHALL have port sel  input  CW  channel index used when sel_mode=1.
REQ-010 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-011 SHALL have port out_chan  output  CW  channel index of out_data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_chan hold a word.
REQ-013 SHALL have port out_ready  input  1  downstream consumes word when out_valid also high.

Function
REQ-014 Output stage SHALL be a single-entry register; load_ok = ~out_valid | out_ready.
REQ-015 Direct mode: grant SHALL be sel when sel < CHANNELS and in_valid[sel]=1; otherwise no grant (sel >= CHANNELS never grants).
REQ-016 Arbitrated mode: grant SHALL be the first channel with in_valid high searching from priority pointer rr_ptr upward, wrapping CHANNELS-1 -> 0.
REQ-017 in_ready[i] SHALL be 1 only for i = grant and only when load_ok; at most one bit high; combinational from inputs and state.
REQ-018 On transfer (in_valid[g] & in_ready[g]) the next edge SHALL load out_data = channel g word, out_chan = g, out_valid = 1; latency one cycle.
REQ-019 If out_valid & out_ready and no transfer, out_valid SHALL clear at the next edge; out_data/out_chan hold value.
REQ-020 Simultaneous drain and transfer SHALL keep out_valid = 1 with the new word; no bubble, no loss.
REQ-021 While out_valid & ~out_ready, out_data and out_chan SHALL remain stable and all in_ready SHALL be 0.
REQ-022 rr_ptr SHALL advance to (g+1) mod CHANNELS after each arbitrated-mode transfer only; unchanged in direct mode and on idle cycles.
REQ-023 Switching sel_mode SHALL take effect in the same cycle; no word in the output register is altered.
REQ-024 CHANNELS = 1 SHALL behave as a registered pass-through; out_chan constant 0.

Reset
REQ-025 resetn low SHALL immediately force out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0, all in_ready = 0, independent of clock.
REQ-026 Reset mid-transfer SHALL discard the held word; first grant after release SHALL follow REQ-015/016 with rr_ptr = 0.

Configuration
REQ-027 Macro CHANNEL_MUX_ARB_RR_EN defined: arbitrated mode SHALL be round-robin per REQ-016/022.
REQ-028 Macro CHANNEL_MUX_ARB_RR_EN undefined: arbitrated mode SHALL be fixed priority, lowest valid index wins; rr_ptr not implemented; direct mode unchanged.

Verification
REQ-029 Reset: resetn=0 mid-stream with out_valid=1 -> out_valid, out_data, out_chan read 0 before next clock edge.
REQ-030 Direct: WIDTH=8, CHANNELS=4, sel_mode=1, sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2.
REQ-031 Round-robin (RR_EN): sel_mode=0, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-032 Fixed priority (RR_EN undefined): same stimulus -> out_chan = 0 every cycle.
REQ-033 Backpressure: out_valid=1 with 8'h3C, out_ready=0 for 5 cycles, in_valid=4'b0010 -> out_data stays 8'h3C, in_ready=0; out_ready=1 -> ch1 word loads next edge, no gap.
REQ-034 Out-of-range/empty: sel_mode=1, CHANNELS=3, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
